// File: rtl/cnn_ctrl_pkg.sv
// Shared types and default sizes for the CNN control blocks.
// Holds the output-memory read FSM encoding and the default frame geometry.
// No logic lives here; everything is imported by the controller modules.
package cnn_ctrl_pkg;

  // Read-controller sequencing: wait for start, issue reads, empty the
  // prefetch path, then flag completion for one cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } rd_state_t;

  // Output frame: N-M+1 result words for N=30 input samples and an M=9 kernel.
  localparam int OUT_DEPTH  = 22;
  localparam int MEM_ADDR_W = 5;

endpackage

// File: rtl/ctrl_rd_skid_fifo.sv
// 2-entry prefetch buffer between the memory read port and the stream output.
// Latency: a push is visible at head the cycle after the push edge (head is a flop).
// Backpressure: none internally; the writer must never push into a full buffer.
module ctrl_rd_skid_fifo #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        count_q, count_d;

  // Next-state of the two slots; head always holds the oldest word.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = push_data;
        end else begin
          tail_d = push_data;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        // Only shift when a second word is waiting; an emptied head keeps
        // its stale value, which is harmless because valid drops.
        if (count_q == 2'd2) begin
          head_d = tail_q;
        end
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push and pop: occupancy is unchanged, the new word
        // lands either directly in head or behind the promoted tail.
        if (count_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: begin
      end
    endcase
  end

  // Slot and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = head_q;

  // The issue logic upstream guarantees room for every in-flight read.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count_q == 2'd2)));

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(pop && (count_q == 2'd0)));

endmodule

// File: rtl/ctrl_mem_read.sv
// Streams DEPTH result words from the output memory to an AXI-stream slave.
// Latency: first read the cycle after start, first word two cycles after that read; 1 word/cycle sustained.
// Backpressure: m_ready low holds m_valid/m_data; reads stall once buffer+in-flight reach 2.
// Optional macro CTRL_MEM_READ_TLAST_EN adds the m_last output marking the final beat.
module ctrl_mem_read
  import cnn_ctrl_pkg::*;
#(
  parameter int DEPTH  = OUT_DEPTH,
  parameter int DATA_W = 16,
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
`ifdef CTRL_MEM_READ_TLAST_EN
  output logic              m_last,
`endif
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_BEAT_C = CNT_W'(DEPTH - 1);

  rd_state_t         state_q, state_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q, inflight_d;

  logic [1:0]        buf_count;
  logic [DATA_W-1:0] buf_head;
  logic              pop;
  logic              rd_en;
  logic              last_beat;
  logic [2:0]        occupancy;

  // Words already buffered plus the read still returning, minus the word
  // leaving this cycle: this is what the buffer will hold once the current
  // in-flight word lands, so a new read is safe while it stays below 2.
  assign pop       = m_valid & m_ready;
  assign occupancy = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign last_beat = (beat_q == LAST_BEAT_C);

  // Read strobe; the m_ready -> mem_rd_en path is deliberately combinational
  // so a draining buffer can refill in the same cycle.
  always_comb begin
    rd_en = (state_q == STREAM) && (issued_q < DEPTH_C) && (occupancy < 3'd2);
  end

  // Sequencing, issue address and beat bookkeeping.
  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    beat_d     = beat_q;
    addr_d     = addr_q;
    inflight_d = rd_en;

    if (rd_en) begin
      issued_d = issued_q + 1'b1;
      addr_d   = addr_q + 1'b1;
    end

    if (pop) begin
      beat_d = beat_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = STREAM;
          issued_d = '0;
          beat_d   = '0;
          addr_d   = '0;
        end
      end
      STREAM: begin
        if (issued_q == DEPTH_C) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && last_beat) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d  = IDLE;
        addr_d   = '0;
        issued_d = '0;
        beat_d   = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller registers; a reset mid-frame abandons the frame without done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      beat_q     <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      beat_q     <= beat_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
    end
  end

  // Prefetch buffer: captures the memory word the cycle after each read.
  ctrl_rd_skid_fifo #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight_q),
    .push_data(mem_rd_data),
    .pop      (pop),
    .count    (buf_count),
    .head     (buf_head)
  );

  assign mem_rd_en = rd_en;
  assign mem_addr  = addr_q;
  assign m_valid   = (buf_count != 2'd0);
  assign m_data    = buf_head;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

`ifdef CTRL_MEM_READ_TLAST_EN
  // Beat counter tracks the head index, so last is stable under backpressure.
  assign m_last = m_valid & last_beat;
`endif

endmodule

// File: tb/tb_ctrl_mem_read.sv
// Self-checking bench for ctrl_mem_read: memory model, queue scoreboard, protocol monitor.
module tb_ctrl_mem_read;

  localparam int DEPTH  = 22;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic              busy;
  logic              done;
`ifdef CTRL_MEM_READ_TLAST_EN
  logic              m_last;
`endif

  ctrl_mem_read #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
`ifdef CTRL_MEM_READ_TLAST_EN
    .m_last     (m_last),
`endif
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] exp_q [$];

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int frame_beats = 0;
  int issued_tot = 0;
  int popped_tot = 0;
  int rd_total = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int done_cyc = 0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: event not seen within cycle budget", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Synchronous memory: a read sampled in one cycle returns data the next.
  initial begin
    logic rd;
    int   a;
    mem_rd_data = '0;
    forever begin
      @(negedge clk);
      rd = mem_rd_en;
      a  = int'(mem_addr);
      @(posedge clk);
      #1;
      mem_rd_data = rd ? mem[a] : DATA_W'($urandom);
    end
  end

  // Monitor: scoreboard pops, stall stability, outstanding-read bound, last flag.
  always @(negedge clk) begin
    logic hs;
    int   occ;
    if (reset) begin
      frame_beats = 0;
      issued_tot  = 0;
      popped_tot  = 0;
      prev_stall  = 1'b0;
    end else begin
      hs = m_valid && m_ready;
      if (prev_stall) begin
        chk("stall_valid_held", 32'(m_valid), 32'd1);
        chk("stall_data_held", 32'(m_data), 32'(prev_data));
      end
      occ = issued_tot - popped_tot - (hs ? 1 : 0) + (mem_rd_en ? 1 : 0);
      chk("outstanding_le2", 32'(occ <= 2), 32'd1);
`ifdef CTRL_MEM_READ_TLAST_EN
      if (m_valid) chk("m_last", 32'(m_last), 32'(frame_beats == DEPTH - 1));
      else         chk("m_last_idle", 32'(m_last), 32'd0);
`endif
      if (hs) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL beat_unexpected: got data %0h expected no beat", m_data);
        end else begin
          chk("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
        if (frame_beats == 0) first_cyc = cyc;
        last_cyc = cyc;
        popped_tot++;
        frame_beats = (frame_beats == DEPTH - 1) ? 0 : frame_beats + 1;
      end
      if (mem_rd_en) begin
        issued_tot++;
        rd_total++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic start_frame();
    start = 1'b1;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(mem[i]);
    exp_done++;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int  base;
    logic got;
    base = done_cnt;
    got  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != base) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    if (!got) fail_now(name);
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (frame_beats == n) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    if (!got) fail_now(name);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic got;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);
    reset   = 1'b1;
    start   = 1'b0;
    m_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Full-rate frame: one read address per cycle, consecutive beats, done after last beat
    m_ready = 1'b1;
    start_frame();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("t1_rd_en", 32'(mem_rd_en), 32'd1);
      chk("t1_addr", 32'(mem_addr), 32'(i));
      tick();
    end
    @(negedge clk);
    chk("t1_rd_stop", 32'(mem_rd_en), 32'd0);
    wait_done(60, "t1_done");
    chk("t1_beats_consecutive", 32'(last_cyc - first_cyc), 32'(DEPTH - 1));
    chk("t1_done_after_last", 32'(done_cyc - last_cyc), 32'd1);
    @(negedge clk);
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_addr_after", 32'(mem_addr), 32'd0);
    chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();

    // Stalled from the start: exactly two reads, head held
    m_ready = 1'b0;
    base = rd_total;
    start_frame();
    repeat (10) tick();
    @(negedge clk);
    chk("t2_reads_issued", 32'(rd_total - base), 32'd2);
    chk("t2_addr", 32'(mem_addr), 32'd2);
    chk("t2_m_valid", 32'(m_valid), 32'd1);
    chk("t2_m_data", 32'(m_data), 32'(mem[0]));
    chk("t2_busy", 32'(busy), 32'd1);
    tick();
    m_ready = 1'b1;
    wait_done(100, "t2_done");
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Random backpressure over three frames, stray starts while busy and on done
    for (int f = 0; f < 3; f++) begin
      m_ready = 1'($urandom_range(0, 1));
      start_frame();
      got = 1'b0;
      for (int n = 0; n < 600; n++) begin
        m_ready = 1'($urandom_range(0, 1));
        if (done) begin
          got   = 1'b1;
          start = (f == 2);
          tick();
          start = 1'b0;
          break;
        end
        start = busy && ($urandom_range(0, 5) == 0);
        tick();
      end
      start = 1'b0;
      if (!got) fail_now("t3_frame_done");
    end
    m_ready = 1'b1;
    repeat (30) tick();
    @(negedge clk);
    chk("t3_idle_after_done_start", 32'(busy), 32'd0);
    chk("t3_no_valid", 32'(m_valid), 32'd0);
    chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("t3_done_count", 32'(done_cnt), 32'(exp_done));
    tick();

    // Reset mid-frame at beat 10, then a clean restart from word 0
    m_ready = 1'b1;
    start_frame();
    wait_beats(10, 100, "t4_beat10");
    m_ready = 1'b0;
    reset   = 1'b1;
    exp_q.delete();
    exp_done--;
    tick();
    reset = 1'b0;
    base  = done_cnt;
    @(negedge clk);
    chk("t4_m_valid", 32'(m_valid), 32'd0);
    chk("t4_rd_en", 32'(mem_rd_en), 32'd0);
    chk("t4_addr", 32'(mem_addr), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    repeat (30) tick();
    chk("t4_no_done", 32'(done_cnt), 32'(base));
    m_ready = 1'b1;
    start_frame();
    wait_done(100, "t4_restart_done");
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef CTRL_MEM_READ_TLAST_EN
    // Hold the final beat under backpressure
    m_ready = 1'b1;
    start_frame();
    wait_beats(DEPTH - 1, 100, "t5_last_head");
    m_ready = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("t5_valid", 32'(m_valid), 32'd1);
    chk("t5_last", 32'(m_last), 32'd1);
    chk("t5_data", 32'(m_data), 32'(mem[DEPTH-1]));
    tick();
    m_ready = 1'b1;
    wait_done(20, "t5_done");
`endif

    repeat (3) tick();
    chk("final_done_count", 32'(done_cnt), 32'(exp_done));
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
